// File: rtl/serial_paralelo_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx_pkg
// Shared definitions for the serial receive path: default comma and idle byte
// values, default lock parameters, and the receiver state encoding.
// The transmitter uses the same byte values, so keep them in step with it.
// -----------------------------------------------------------------------------
package serial_paralelo_rx_pkg;

    // Comma / alignment byte, sent by the transmitter when the lanes are idle
    localparam logic [7:0] COM_BYTE_DEF      = 8'hBC;
    // Idle filler byte, never forwarded as valid data
    localparam logic [7:0] IDLE_BYTE_DEF     = 8'h7C;
    // Consecutive aligned commas required before the link is declared active
    localparam int         BC_COUNT_DEF      = 4;
    // Longest run of data bytes tolerated while locked (lock-loss build only)
    localparam int         MAX_DATA_RUN_DEF  = 64;

    // Receiver state encoding
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

    // A byte that carries no payload: comma or idle filler
    function automatic logic is_filler(input logic is_com, input logic is_idle);
        return is_com | is_idle;
    endfunction

endpackage

// File: rtl/serial_paralelo_rx_com_detector.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx_com_detector
// Serial history register plus byte-window comparator. The window is the byte
// that ends at the bit currently on data_i (MSB first), so a comma is seen on
// the same edge that samples its last bit.
//
// Ports:
//   clk_i      in   bit clock, rising edge
//   rst_ni     in   asynchronous active-low reset, clears the history
//   data_i     in   serial bit
//   window_o   out  8-bit window {last 7 bits, data_i} (combinational)
//   is_com_o   out  window equals the comma byte
//   is_idle_o  out  window equals the idle byte
// -----------------------------------------------------------------------------
module serial_paralelo_rx_com_detector
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COM_BYTE  = COM_BYTE_DEF,
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       data_i,
    output logic [7:0] window_o,
    output logic       is_com_o,
    output logic       is_idle_o
);

    // Only the seven most recent bits are stored; the eighth bit of the
    // window is the live input, so an eighth history bit would never be read.
    logic [6:0] sr_q;
    logic [6:0] sr_d;

    assign window_o  = {sr_q, data_i};
    assign sr_d      = window_o[6:0];
    assign is_com_o  = (window_o == COM_BYTE);
    assign is_idle_o = (window_o == IDLE_BYTE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
// Receive-side deserializer. Searches the bitstream for the comma byte at any
// bit phase, confirms alignment with BC_COUNT consecutive commas on byte
// boundaries, then forwards each non-filler byte with a valid flag and a
// one-cycle strobe per byte boundary.
//
// Optional feature macro: RX_LOCK_LOSS_EN
//   Defined   : a run of MAX_DATA_RUN+1 consecutive data bytes while ACTIVE
//               drops the lock and returns to SEARCH.
//   Undefined : ACTIVE is left only through reset.
//
// Ports:
//   clk_32f      in   serial bit clock, all logic on rising edge
//   reset        in   asynchronous active-low reset
//   data_in      in   serial bit, MSB first
//   data_out     out  last forwarded data byte
//   valid_out    out  data_out holds a data byte from the current byte slot
//   byte_strobe  out  one-cycle pulse at each byte boundary while ACTIVE
//   active       out  link aligned and locked
// -----------------------------------------------------------------------------
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COM_BYTE     = COM_BYTE_DEF,
    parameter logic [7:0] IDLE_BYTE    = IDLE_BYTE_DEF,
    parameter int         BC_COUNT     = BC_COUNT_DEF,
    parameter int         MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

    // -------------------------------------------------------------------------
    // Window / comma detection
    // -------------------------------------------------------------------------
    logic [7:0] window;
    logic       is_com;
    logic       is_idle;

    serial_paralelo_rx_com_detector #(
        .COM_BYTE  (COM_BYTE),
        .IDLE_BYTE (IDLE_BYTE)
    ) u_com_detector (
        .clk_i     (clk_32f),
        .rst_ni    (reset),
        .data_i    (data_in),
        .window_o  (window),
        .is_com_o  (is_com),
        .is_idle_o (is_idle)
    );

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    rx_state_e  state_q,   state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q,  bc_cnt_d;
    logic [7:0] data_q,    data_d;
    logic       valid_q,   valid_d;
    logic       strobe_q,  strobe_d;
    logic       active_q,  active_d;
    logic       boundary;

`ifdef RX_LOCK_LOSS_EN
    // Wide enough to hold MAX_DATA_RUN; the byte that would push the count
    // past it is the one that drops the lock.
    localparam int             RUN_W     = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_DATA_RUN);

    logic [RUN_W-1:0] run_q, run_d;
`endif

    // bit_cnt is re-zeroed on the edge that completes the first comma, so it
    // reads 7 exactly on edges that sample the last bit of an aligned byte.
    assign boundary = (bit_cnt_q == 3'd7);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
        active_d  = active_q;
`ifdef RX_LOCK_LOSS_EN
        run_d     = run_q;
`endif

        case (state_q)
            SEARCH: begin
                // Bit-by-bit hunt: any of the 8 phases can lock here.
                if (is_com) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 4'd1;
                    if (BC_TARGET == 4'd1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        bc_cnt_d = bc_cnt_q + 4'd1;
                        if ((bc_cnt_q + 4'd1) == BC_TARGET) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Broken comma sequence: start over from scratch. The
                        // offending window is not re-examined as a comma.
                        state_d  = SEARCH;
                        bc_cnt_d = 4'd0;
                    end
                end
            end

            ACTIVE: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (is_filler(is_com, is_idle)) begin
                        // Filler keeps the last payload byte on data_out.
                        valid_d = 1'b0;
`ifdef RX_LOCK_LOSS_EN
                        run_d   = '0;
`endif
                    end else begin
`ifdef RX_LOCK_LOSS_EN
                        if (run_q == RUN_LIMIT) begin
                            // Too long without a comma or idle: assume we
                            // slipped alignment. data_out keeps the last good byte.
                            state_d  = SEARCH;
                            active_d = 1'b0;
                            valid_d  = 1'b0;
                            bc_cnt_d = 4'd0;
                            run_d    = '0;
                        end else begin
                            data_d  = window;
                            valid_d = 1'b1;
                            run_d   = run_q + RUN_W'(1);
                        end
`else
                        data_d  = window;
                        valid_d = 1'b1;
`endif
                    end
                end
            end

            default: begin
                state_d  = SEARCH;
                bc_cnt_d = 4'd0;
                active_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q   <= SEARCH;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
        end
    end

`ifdef RX_LOCK_LOSS_EN
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`endif

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_rx
// Directed bench for serial_paralelo_rx: reset hold, comma alignment at an odd
// bit phase, filler suppression, broken comma sequence, asynchronous reset
// mid-byte, and the long-data-run behaviour with and without RX_LOCK_LOSS_EN.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_rx;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int tests_run = 0;
    int tests_failed = 0;
    int strobes = 0;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_rx #(
        .BC_COUNT     (4),
        .MAX_DATA_RUN (4)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, let the edge sample it, then look 1 ns after the edge.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        if (byte_strobe === 1'b1) strobes++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk_32f);
        #1;
        @(posedge clk_32f);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] bc;
        bc = 8'hBC;

        // ---- Reset held while data toggles ----
        for (int i = 0; i < 12; i++) begin
            send_bit(i[0]);
            chk("reset_hold", 32'({data_out, valid_out, byte_strobe, active}), 32'h0);
        end
        reset = 1'b1;
        $display("[TB] reset hold done");

        // ---- 3 stray bits then 4 commas ----
        strobes = 0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC);
            chk("align_not_yet", 32'(active), 32'h0);
        end
        for (int i = 7; i >= 1; i--) send_bit(bc[i]);
        chk("align_pre_last_bit", 32'(active), 32'h0);
        send_bit(bc[0]);
        chk("align_active", 32'(active), 32'h1);
        chk("align_no_strobe", 32'(strobes), 32'h0);
        chk("align_valid_low", 32'(valid_out), 32'h0);
        $display("[TB] lock after 4 commas: active=%0d strobes=%0d", active, strobes);

        // ---- A5, 7C, 3C, BC ----
        strobes = 0;
        send_byte(8'hA5);
        chk("a5_strobe", 32'(byte_strobe), 32'h1);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_valid", 32'(valid_out), 32'h1);
        $display("[TB] byte A5: data=%02h valid=%0d", data_out, valid_out);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("a5_strobe_one_cycle", 32'(byte_strobe), 32'h0);
        chk("a5_held_valid", 32'(valid_out), 32'h1);
        chk("a5_held_data", 32'(data_out), 32'hA5);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        chk("7c_valid", 32'(valid_out), 32'h0);
        chk("7c_data", 32'(data_out), 32'hA5);
        $display("[TB] byte 7C: data=%02h valid=%0d", data_out, valid_out);
        send_byte(8'h3C);
        chk("3c_data", 32'(data_out), 32'h3C);
        chk("3c_valid", 32'(valid_out), 32'h1);
        $display("[TB] byte 3C: data=%02h valid=%0d", data_out, valid_out);
        send_byte(8'hBC);
        chk("bc_valid", 32'(valid_out), 32'h0);
        chk("bc_data", 32'(data_out), 32'h3C);
        chk("four_strobes", 32'(strobes), 32'h4);
        $display("[TB] byte BC: data=%02h valid=%0d strobes=%0d", data_out, valid_out, strobes);

        // ---- Broken comma sequence ----
        pulse_reset();
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'h55);
        chk("broken_after_55", 32'(active), 32'h0);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        chk("broken_3_new_bc", 32'(active), 32'h0);
        send_byte(8'hBC);
        chk("broken_relock", 32'(active), 32'h1);
        $display("[TB] broken sequence relock: active=%0d", active);

        // ---- Asynchronous reset mid-byte ----
        send_byte(8'h12);
        chk("pre_reset_data", 32'(data_out), 32'h12);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_clear", 32'({data_out, valid_out, byte_strobe, active}), 32'h0);
        @(posedge clk_32f);
        #1;
        @(posedge clk_32f);
        #1;
        reset = 1'b1;
        strobes = 0;
        send_byte(8'hA5);
        chk("post_reset_no_strobe", 32'(strobes), 32'h0);
        chk("post_reset_inactive", 32'(active), 32'h0);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        chk("post_reset_relock", 32'(active), 32'h1);
        chk("post_reset_relock_no_strobe", 32'(strobes), 32'h0);
        $display("[TB] async reset mid-byte then relock: active=%0d", active);

        // ---- Long data run ----
        for (int k = 1; k <= 4; k++) begin
            send_byte(8'(k));
            chk("run_data", 32'(data_out), 32'(k));
            chk("run_valid", 32'(valid_out), 32'h1);
        end
        strobes = 0;
        send_byte(8'h05);
        chk("run5_strobe", 32'(strobes), 32'h1);
`ifdef RX_LOCK_LOSS_EN
        chk("run5_active", 32'(active), 32'h0);
        chk("run5_valid", 32'(valid_out), 32'h0);
        chk("run5_data", 32'(data_out), 32'h04);
`else
        chk("run5_active", 32'(active), 32'h1);
        chk("run5_valid", 32'(valid_out), 32'h1);
        chk("run5_data", 32'(data_out), 32'h05);
`endif
        $display("[TB] 5th data byte: active=%0d valid=%0d data=%02h", active, valid_out, data_out);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
